dmac_channel_arbiter: RTL and testbench
=======================================

DMAC_CHANNEL_ARBITER -- requirements
Module: dmac_channel_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of DMA channels sharing the AHB master port (2..8).
REQ-002 Parameter QUANTUM, default 16: maximum grant length in clock cycles before preemption when another channel is waiting.
REQ-003 clk  in  1  single clock, rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ch_req  in  NUM_CH  level request per channel; held high until that channel's transfer completes.
REQ-006 ch_done  in  NUM_CH  one-cycle completion pulse per channel (channel irq).
REQ-007 readyIn  in  1  AHB HREADY seen by the master port.
REQ-008 channel_en  out  NUM_CH  one-hot-or-zero enable driving each channel controller.
REQ-009 grant_id  out  $clog2(NUM_CH)  index of the granted channel; 0 when none.
REQ-010 grant_valid  out  1  high while any channel_en bit is high.
REQ-011 irq  out  NUM_CH  one-cycle completion pulse per channel, registered.

Function
REQ-012 States SHALL be ARB_IDLE, ARB_ACTIVE and ARB_RELEASE; all outputs registered.
REQ-013 ARB_IDLE: if any ch_req is high, the winner SHALL be the first requester at or after rr_ptr, ascending and wrapping modulo NUM_CH; next cycle state=ARB_ACTIVE and channel_en[winner]=1.
REQ-014 Request-to-enable latency SHALL be exactly 1 cycle from an ARB_IDLE cycle with ch_req high.
REQ-015 ARB_ACTIVE: qcnt SHALL reset to 0 on entry and increment each cycle, saturating at QUANTUM-1.
REQ-016 ARB_ACTIVE with ch_done[grant_id]=1: channel_en cleared, irq[grant_id] pulsed next cycle, rr_ptr=grant_id+1 mod NUM_CH, state=ARB_IDLE.
REQ-017 ARB_ACTIVE with qcnt==QUANTUM-1 and another channel requesting: channel_en cleared, state=ARB_RELEASE.
REQ-018 ARB_ACTIVE with ch_req[grant_id] dropped and no ch_done: channel_en cleared, state=ARB_RELEASE, no irq.
REQ-019 qcnt==QUANTUM-1 with no other requester: grant SHALL be kept; qcnt holds at QUANTUM-1 so preemption fires on the first cycle another request appears.
REQ-020 Simultaneous ch_done and quantum expiry: ch_done SHALL take priority.
REQ-021 ARB_RELEASE: wait while readyIn=0; on the first cycle with readyIn=1, rr_ptr=grant_id+1 mod NUM_CH and state=ARB_IDLE.
REQ-022 ch_done arriving in ARB_RELEASE SHALL still produce the irq pulse.
REQ-023 A preempted channel SHALL keep its request and be re-enabled later without a restart.
REQ-024 ch_done from a non-granted channel SHALL be ignored.
REQ-025 At least one ARB_IDLE cycle SHALL separate successive grants; channel_en SHALL never have two bits high.

Reset
REQ-026 rst SHALL force state=ARB_IDLE, rr_ptr=0, qcnt=0, channel_en=0, grant_id=0, grant_valid=0 and irq=0 on the next rising edge.
REQ-027 Reset asserted mid-grant SHALL drop channel_en in the same edge; in-flight completions are discarded.

Structure
REQ-028 The arb_state_t enum and the AHB HTrans encoding constants SHALL live in a shared package, dmac_pkg, which the channel controller also imports.
REQ-029 Rotating-priority selection SHALL be a combinational sub-module, dmac_rr_pick (inputs req and ptr; outputs valid and idx).

Verification (NUM_CH=4, QUANTUM=16)
REQ-030 ch_req=0001 at t0 -> channel_en=0001 at t1; ch_done[0] at t5 -> channel_en=0000 at t6, irq=0001 at t6 only.
REQ-031 ch_req=1111 continuously, each done after 3 cycles -> grant order 0,1,2,3,0 with one ARB_IDLE cycle between grants.
REQ-032 ch_req=0011, channel 0 never done, readyIn=1 -> channel_en[0] drops after 16 active cycles and channel 1 is granted 2 cycles later.
REQ-033 Same as REQ-032 but readyIn=0 for 5 cycles in ARB_RELEASE -> channel 1 grant delayed by exactly 5 cycles.
REQ-034 ch_done[0] coincides with quantum expiry and ch_req[1]=1 -> irq[0] pulses and rr_ptr=1.
REQ-035 rst asserted during ARB_ACTIVE -> all outputs 0 next edge; after release, ch_req=0100 is granted channel 2 in 1 cycle.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared DMA-controller definitions: arbiter state encoding, AHB HTRANS codes
// and a small width helper used wherever a counter or index is sized.
package dmac_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_ACTIVE  = 2'b01,
        ARB_RELEASE = 2'b10
    } arb_state_t;

    // AHB HTRANS encodings driven by the channel controllers on the master port.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or after
// ptr, scanning upward and wrapping modulo NUM_CH. Purely combinational.
module dmac_rr_pick
    import dmac_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic                      valid,
    output logic [$clog2(NUM_CH)-1:0] idx
);

    localparam int IW = $clog2(NUM_CH);

    logic [IW:0]   w_sum      [NUM_CH];
    logic [IW-1:0] w_cand_idx [NUM_CH];
    logic [NUM_CH-1:0] w_cand_req;

    // Candidate gi is the channel gi positions after ptr (modulo NUM_CH).
    // One extra bit on the sum keeps the wrap correct for any NUM_CH.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
        assign w_sum[gi]      = {1'b0, ptr} + (IW+1)'(gi);
        assign w_cand_idx[gi] = (w_sum[gi] >= (IW+1)'(NUM_CH))
                              ? IW'(w_sum[gi] - (IW+1)'(NUM_CH))
                              : w_sum[gi][IW-1:0];
        assign w_cand_req[gi] = req[w_cand_idx[gi]];
    end

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                valid = 1'b1;
                idx   = w_cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/dmac_channel_arbiter.sv
// Round-robin, quantum-limited arbiter granting one DMA channel at a time
// access to the shared AHB master port. All outputs come straight from flops.
module dmac_channel_arbiter
    import dmac_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int QUANTUM = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_done,
    input  logic                      readyIn,
    output logic [NUM_CH-1:0]         channel_en,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      grant_valid,
    output logic [NUM_CH-1:0]         irq
);

    localparam int IW = $clog2(NUM_CH);
    localparam int QW = idx_width(QUANTUM);
    localparam logic [QW-1:0] QMAX = QW'(QUANTUM - 1);

    arb_state_t         r_state,       w_state_next;
    logic [IW-1:0]      r_rr_ptr,      w_rr_ptr_next;
    logic [QW-1:0]      r_qcnt,        w_qcnt_next;
    // Owner survives into ARB_RELEASE (grant_id is already 0 there) so the
    // round-robin pointer and a late completion still know who held the bus.
    logic [IW-1:0]      r_owner,       w_owner_next;
    logic [NUM_CH-1:0]  r_channel_en,  w_channel_en_next;
    logic [IW-1:0]      r_grant_id,    w_grant_id_next;
    logic               r_grant_valid, w_grant_valid_next;
    logic [NUM_CH-1:0]  r_irq,         w_irq_next;

    logic               w_pick_valid;
    logic [IW-1:0]      w_pick_idx;
    logic               w_others_req;

    function automatic logic [IW-1:0] f_next_idx(input logic [IW-1:0] i);
        if (i == IW'(NUM_CH - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    dmac_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req   (ch_req),
        .ptr   (r_rr_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // While active, channel_en is exactly the owner's bit.
    assign w_others_req = |(ch_req & ~r_channel_en);

    // State and output registers; reset also discards any pending completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_rr_ptr      <= '0;
            r_qcnt        <= '0;
            r_owner       <= '0;
            r_channel_en  <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_irq         <= '0;
        end else begin
            r_state       <= w_state_next;
            r_rr_ptr      <= w_rr_ptr_next;
            r_qcnt        <= w_qcnt_next;
            r_owner       <= w_owner_next;
            r_channel_en  <= w_channel_en_next;
            r_grant_id    <= w_grant_id_next;
            r_grant_valid <= w_grant_valid_next;
            r_irq         <= w_irq_next;
        end
    end

    // Next-state and next-output logic; irq is a single-cycle pulse.
    always_comb begin
        w_state_next       = r_state;
        w_rr_ptr_next      = r_rr_ptr;
        w_qcnt_next        = r_qcnt;
        w_owner_next       = r_owner;
        w_channel_en_next  = r_channel_en;
        w_grant_id_next    = r_grant_id;
        w_grant_valid_next = r_grant_valid;
        w_irq_next         = '0;

        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next                  = ARB_ACTIVE;
                    w_owner_next                  = w_pick_idx;
                    w_channel_en_next             = '0;
                    w_channel_en_next[w_pick_idx] = 1'b1;
                    w_grant_id_next               = w_pick_idx;
                    w_grant_valid_next            = 1'b1;
                    w_qcnt_next                   = '0;
                end
            end

            ARB_ACTIVE: begin
                // Completion outranks quantum expiry and request withdrawal.
                if (ch_done[r_owner]) begin
                    w_irq_next[r_owner] = 1'b1;
                    w_channel_en_next   = '0;
                    w_grant_id_next     = '0;
                    w_grant_valid_next  = 1'b0;
                    w_rr_ptr_next       = f_next_idx(r_owner);
                    w_state_next        = ARB_IDLE;
                end else if (!ch_req[r_owner] || (r_qcnt == QMAX && w_others_req)) begin
                    w_channel_en_next  = '0;
                    w_grant_id_next    = '0;
                    w_grant_valid_next = 1'b0;
                    w_state_next       = ARB_RELEASE;
                end else if (r_qcnt != QMAX) begin
                    // Saturating so a later requester preempts immediately.
                    w_qcnt_next = r_qcnt + 1'b1;
                end
            end

            ARB_RELEASE: begin
                // Let the in-flight bus beat finish before re-arbitrating.
                if (ch_done[r_owner]) begin
                    w_irq_next[r_owner] = 1'b1;
                end
                if (readyIn) begin
                    w_rr_ptr_next = f_next_idx(r_owner);
                    w_state_next  = ARB_IDLE;
                end
            end

            default: begin
                w_state_next       = ARB_IDLE;
                w_channel_en_next  = '0;
                w_grant_id_next    = '0;
                w_grant_valid_next = 1'b0;
            end
        endcase
    end

    assign channel_en  = r_channel_en;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign irq         = r_irq;

endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// Directed bench for dmac_channel_arbiter (NUM_CH=4, QUANTUM=16). Each step
// pushes the expected registered outputs, clocks once, then pops and compares.
module tb_dmac_channel_arbiter;

    localparam int NUM_CH  = 4;
    localparam int QUANTUM = 16;

    typedef struct packed {
        logic [3:0] en;
        logic [1:0] gid;
        logic       gv;
        logic [3:0] irq;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] ch_req;
    logic [3:0] ch_done;
    logic       readyIn;
    logic [3:0] channel_en;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic [3:0] irq;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks;
    int    n_pass;

    dmac_channel_arbiter #(
        .NUM_CH  (NUM_CH),
        .QUANTUM (QUANTUM)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ch_req      (ch_req),
        .ch_done     (ch_done),
        .readyIn     (readyIn),
        .channel_en  (channel_en),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push the outputs expected after the next edge, clock, then pop and check.
    task automatic cyc(input string tag, input logic [3:0] en, input logic [3:0] irq_e);
        exp_t  e;
        exp_t  o;
        string t;
        e.en  = en;
        e.gid = en[3] ? 2'd3 : en[2] ? 2'd2 : en[1] ? 2'd1 : 2'd0;
        e.gv  = |en;
        e.irq = irq_e;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {channel_en, grant_id, grant_valid, irq};
        n_checks++;
        assert (o === e) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed en=%b gid=%0d gv=%b irq=%b, expected en=%b gid=%0d gv=%b irq=%b",
                   t, o.en, o.gid, o.gv, o.irq, e.en, e.gid, e.gv, e.irq);
        end
        $display("step %-14s en=%b gid=%0d gv=%b irq=%b", t, o.en, o.gid, o.gv, o.irq);
    endtask

    initial begin
        int         order [5];
        logic [3:0] oh;
        n_checks = 0;
        n_pass   = 0;
        order    = '{0, 1, 2, 3, 0};

        // Reset state
        rst = 1'b1; ch_req = '0; ch_done = '0; readyIn = 1'b1;
        cyc("reset", 4'b0000, 4'b0000);
        cyc("reset", 4'b0000, 4'b0000);

        // Single channel: enable 1 cycle after request, irq only on the done edge
        rst = 1'b0; ch_req = 4'b0001;
        cyc("single_grant", 4'b0001, 4'b0000);
        for (int i = 0; i < 4; i++) cyc("single_hold", 4'b0001, 4'b0000);
        ch_done = 4'b0001;
        cyc("single_done", 4'b0000, 4'b0001);
        ch_done = '0; ch_req = '0;
        cyc("single_quiet", 4'b0000, 4'b0000);

        // All channels requesting, each done after 3 cycles: 0,1,2,3,0
        rst = 1'b1;
        cyc("reset2", 4'b0000, 4'b0000);
        rst = 1'b0; ch_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            oh = 4'b0001 << order[n];
            for (int i = 0; i < 3; i++) cyc("rr_grant", oh, 4'b0000);
            ch_done = oh;
            cyc("rr_idle_irq", 4'b0000, oh);
            ch_done = '0;
            if (n == 4) ch_req = '0;
        end
        cyc("rr_quiet", 4'b0000, 4'b0000);

        // Quantum preemption with readyIn=1, then non-granted done ignored
        rst = 1'b1;
        cyc("reset3", 4'b0000, 4'b0000);
        rst = 1'b0; ch_req = 4'b0011;
        for (int i = 0; i < QUANTUM; i++) cyc("q_active", 4'b0001, 4'b0000);
        cyc("q_release", 4'b0000, 4'b0000);
        cyc("q_idle", 4'b0000, 4'b0000);
        cyc("q_grant1", 4'b0010, 4'b0000);
        ch_done = 4'b0001;
        cyc("foreign_done", 4'b0010, 4'b0000);
        ch_done = 4'b0010;
        cyc("q_done1", 4'b0000, 4'b0010);
        ch_done = '0; ch_req = 4'b0001;
        cyc("q_regrant0", 4'b0001, 4'b0000);
        ch_done = 4'b0001; ch_req = '0;
        cyc("q_done0", 4'b0000, 4'b0001);
        ch_done = '0;
        cyc("q_quiet", 4'b0000, 4'b0000);

        // Quantum preemption with readyIn low for 5 release cycles, done in release
        rst = 1'b1;
        cyc("reset4", 4'b0000, 4'b0000);
        rst = 1'b0; ch_req = 4'b0011; readyIn = 1'b0;
        for (int i = 0; i < QUANTUM; i++) cyc("w_active", 4'b0001, 4'b0000);
        cyc("w_release", 4'b0000, 4'b0000);
        cyc("w_release", 4'b0000, 4'b0000);
        ch_done = 4'b0001; ch_req = 4'b0010;
        cyc("w_rel_irq", 4'b0000, 4'b0001);
        ch_done = '0;
        for (int i = 0; i < 3; i++) cyc("w_release", 4'b0000, 4'b0000);
        readyIn = 1'b1;
        cyc("w_idle", 4'b0000, 4'b0000);
        cyc("w_grant1", 4'b0010, 4'b0000);
        ch_done = 4'b0010; ch_req = '0;
        cyc("w_done1", 4'b0000, 4'b0010);
        ch_done = '0;
        cyc("w_quiet", 4'b0000, 4'b0000);

        // Done coincides with quantum expiry: done wins, rr_ptr moves to 1
        rst = 1'b1;
        cyc("reset5", 4'b0000, 4'b0000);
        rst = 1'b0; ch_req = 4'b0011;
        for (int i = 0; i < QUANTUM; i++) cyc("c_active", 4'b0001, 4'b0000);
        ch_done = 4'b0001; ch_req = 4'b1010;
        cyc("c_done_wins", 4'b0000, 4'b0001);
        ch_done = '0;
        cyc("c_grant1", 4'b0010, 4'b0000);
        ch_done = 4'b0010; ch_req = 4'b1000;
        cyc("c_done1", 4'b0000, 4'b0010);
        ch_done = '0;
        cyc("c_grant3", 4'b1000, 4'b0000);
        ch_done = 4'b1000; ch_req = '0;
        cyc("c_done3", 4'b0000, 4'b1000);
        ch_done = '0;
        cyc("c_quiet", 4'b0000, 4'b0000);

        // Saturated quantum with a lone requester, then immediate preemption
        ch_req = 4'b0001;
        for (int i = 0; i < QUANTUM + 4; i++) cyc("s_hold", 4'b0001, 4'b0000);
        ch_req = 4'b0011;
        cyc("s_preempt", 4'b0000, 4'b0000);
        cyc("s_idle", 4'b0000, 4'b0000);
        cyc("s_grant1", 4'b0010, 4'b0000);
        cyc("s_grant1", 4'b0010, 4'b0000);
        // Channel 1 withdraws its request without done: release, no irq
        ch_req = 4'b0001;
        cyc("drop_release", 4'b0000, 4'b0000);
        cyc("drop_idle", 4'b0000, 4'b0000);
        cyc("drop_grant0", 4'b0001, 4'b0000);
        cyc("drop_grant0", 4'b0001, 4'b0000);

        // Reset mid-grant discards the completion; then channel 2 in 1 cycle
        rst = 1'b1; ch_done = 4'b0001;
        cyc("mid_reset", 4'b0000, 4'b0000);
        rst = 1'b0; ch_done = '0; ch_req = 4'b0100;
        cyc("post_grant2", 4'b0100, 4'b0000);
        ch_done = 4'b0100; ch_req = '0;
        cyc("post_done2", 4'b0000, 4'b0100);
        ch_done = '0;
        cyc("post_quiet", 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
